// File: rtl/decode_strobe_sequencer_if.sv
// Request and decoder-drive bundle for decode_strobe_sequencer.
// The requester uses master; the sequencer uses slave.
interface decode_strobe_sequencer_if #(
  parameter int WIDTH_IN = 3
);
  logic                req_valid;
  logic [WIDTH_IN-1:0] req_addr;
  logic                req_ready;
  logic [WIDTH_IN-1:0] addr_out;
  logic                en_out;
  logic                busy;
  logic                done;
  logic                err;

  modport master (
    output req_valid,
    output req_addr,
    input  req_ready,
    input  addr_out,
    input  en_out,
    input  busy,
    input  done,
    input  err
  );

  modport slave (
    input  req_valid,
    input  req_addr,
    output req_ready,
    output addr_out,
    output en_out,
    output busy,
    output done,
    output err
  );
endinterface

// File: rtl/decode_strobe_sequencer.sv
// Sequences address setup, enable strobe and hold for a 138-style decoder.
// Every output is a flop, so decoder inputs never glitch.
module decode_strobe_sequencer #(
  parameter int WIDTH_OUT     = 8,
  parameter int WIDTH_IN      = $clog2(WIDTH_OUT),
  parameter int SETUP_CYCLES  = 1,
  parameter int STROBE_CYCLES = 1,
  parameter int HOLD_CYCLES   = 1
) (
  input logic                       clk,
  input logic                       reset,
  decode_strobe_sequencer_if.slave  sif
);

  localparam int MAX_ST = (SETUP_CYCLES > STROBE_CYCLES) ?
                          SETUP_CYCLES : STROBE_CYCLES;
  localparam int MAX_C  = (MAX_ST > HOLD_CYCLES) ?
                          MAX_ST : HOLD_CYCLES;
  localparam int CW     = $clog2(MAX_C + 1);

  localparam logic [CW-1:0] S_LD = CW'(SETUP_CYCLES - 1);
  localparam logic [CW-1:0] T_LD = CW'(STROBE_CYCLES - 1);
  localparam logic [CW-1:0] H_LD = CW'(HOLD_CYCLES - 1);

  if (STROBE_CYCLES < 1) begin : g_bad_strobe
    $error("STROBE_CYCLES must be at least 1");
  end
  if (WIDTH_IN < $clog2(WIDTH_OUT)) begin : g_bad_width
    $error("WIDTH_IN too narrow for WIDTH_OUT");
  end

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    STROBE,
    HOLD
  } state_e;

  state_e              state_q;
  logic [CW-1:0]       cnt_q;
  logic [WIDTH_IN-1:0] addr_q;
  logic                en_q;
  logic                busy_q;
  logic                done_q;
  logic                err_q;
  logic                ready_q;

  logic                xz;
  logic                bad;

  // x/z on the address is only meaningful in simulation
`ifdef SYNTHESIS
  assign xz = 1'b0;
`else
  assign xz = $isunknown(sif.req_addr);
`endif

  assign bad = xz ||
               (32'(sif.req_addr) >= 32'(WIDTH_OUT));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (sif.req_valid && ready_q) begin
            if (bad) begin
              err_q <= 1'b1;
            end else begin
              addr_q  <= sif.req_addr;
              busy_q  <= 1'b1;
              ready_q <= 1'b0;
              if (SETUP_CYCLES > 0) begin
                state_q <= SETUP;
                cnt_q   <= S_LD;
              end else begin
                state_q <= STROBE;
                cnt_q   <= T_LD;
                en_q    <= 1'b1;
              end
            end
          end
        end
        SETUP: begin
          if (cnt_q == '0) begin
            state_q <= STROBE;
            cnt_q   <= T_LD;
            en_q    <= 1'b1;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        STROBE: begin
          if (cnt_q == '0) begin
            en_q <= 1'b0;
            if (HOLD_CYCLES > 0) begin
              state_q <= HOLD;
              cnt_q   <= H_LD;
            end else begin
              state_q <= IDLE;
              cnt_q   <= '0;
              busy_q  <= 1'b0;
              ready_q <= 1'b1;
              done_q  <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        HOLD: begin
          if (cnt_q == '0) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
            done_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
      endcase
    end
  end

  assign sif.req_ready = ready_q;
  assign sif.addr_out  = addr_q;
  assign sif.en_out    = en_q;
  assign sif.busy      = busy_q;
  assign sif.done      = done_q;
  assign sif.err       = err_q;

endmodule

// File: doc/decode_strobe_sequencer.md
Name: decode_strobe_sequencer

Overview:
Upstream driver for the 3-to-8 line decoder used to select register write/read targets. Accepts a target-select request and presents a stable address to the decoder, then a glitch-free active-high enable strobe and a hold window. The decoder's outputs therefore only ever pulse low for the selected line and never glitch while its address inputs change. It sits between control-word decode and the 138-style decoder's A and Enable3 inputs.

Parameters:
WIDTH_OUT, 8, number of decoder output lines served.
WIDTH_IN, $clog2(WIDTH_OUT), address width driven to the decoder.
SETUP_CYCLES, 1, cycles the address is held with enable low before the strobe; 0 allowed.
STROBE_CYCLES, 1, cycles enable is high; minimum 1.
HOLD_CYCLES, 1, cycles the address is held after the strobe with enable low; 0 allowed.

Ports:
clk  input  1  rising-edge clock.
reset  input  1  asynchronous, active-high reset.
req_valid  input  1  request present.
req_addr  input  WIDTH_IN  requested decoder line.
req_ready  output  1  sequencer can accept a request.
addr_out  output  WIDTH_IN  to decoder A inputs.
en_out  output  1  to decoder Enable3; active-high strobe.
busy  output  1  high in any state other than IDLE.
done  output  1  one-cycle pulse after a completed sequence.
err  output  1  one-cycle pulse when a request is rejected.

Behaviour:
- All outputs are registered. No combinational path from req_* to addr_out, en_out, done or err.
- Reset (async assert, sync release) forces state IDLE, addr_out=0, en_out=0, busy=0, done=0, err=0, req_ready=1 and all counters to 0.
- Reset mid-sequence drops en_out immediately, with no clock edge needed. The in-flight request is discarded and no done is issued.
- States: IDLE, SETUP, STROBE, HOLD.
- IDLE: req_ready=1. A request is accepted on a clock edge when req_valid && req_ready.
  - On acceptance, addr_out latches req_addr.
  - Next state is SETUP, or STROBE if SETUP_CYCLES==0.
- SETUP: en_out=0, addr_out stable. Lasts exactly SETUP_CYCLES cycles, then STROBE.
- STROBE: en_out=1 for exactly STROBE_CYCLES cycles, then HOLD, or IDLE if HOLD_CYCLES==0.
- HOLD: en_out=0, addr_out stable. Lasts exactly HOLD_CYCLES cycles, then IDLE.
- done pulses high for one cycle coincident with re-entering IDLE after a completed sequence.
- req_ready=0 in SETUP, STROBE and HOLD. There is no pipelining.
- Minimum request period is 1+SETUP_CYCLES+STROBE_CYCLES+HOLD_CYCLES cycles. With defaults that is 4 cycles.
- addr_out changes only on acceptance. It is held through IDLE afterwards and is never altered while en_out=1.
- en_out changes only on clock edges, apart from async reset.
- Rejection: if an accepted req_addr >= WIDTH_OUT (only possible when WIDTH_OUT is not a power of 2), or req_addr contains x/z:
  - err pulses one cycle.
  - The state stays IDLE, addr_out is unchanged and en_out stays 0.
  - x/z detection is simulation-only, using $isunknown.
- req_valid held high continuously produces back-to-back sequences, each separated by exactly one IDLE cycle.
- req_valid while busy is ignored. The requester must hold the request until it sees req_ready.
- Cycle counters are sized $clog2(max(SETUP_CYCLES,STROBE_CYCLES,HOLD_CYCLES)+1) bits and reload on each state entry.
- Elaboration error if STROBE_CYCLES<1 or WIDTH_IN<$clog2(WIDTH_OUT).

Test Plan:
1. Defaults, reset then req_valid=1 and req_addr=5 for one cycle:
   - addr_out=5 at edge 1.
   - en_out=1 during cycle 3 only.
   - done pulses at edge 4.
   - Decoder model Y=8'b1101_1111 only while en_out=1, and Y=8'hFF otherwise, with no other pattern.
2. req_valid held high with addresses 0,7,3:
   - Three strobes, each with period 4 cycles.
   - addr_out never changes while en_out=1.
   - Three done pulses.
3. WIDTH_OUT=6 and req_addr=6:
   - err pulses one cycle, busy stays 0, en_out stays 0, addr_out keeps its previous value.
   - A following req_addr=2 then sequences normally.
4. SETUP_CYCLES=0, STROBE_CYCLES=3, HOLD_CYCLES=0, req_addr=1:
   - en_out high for cycles 1-3 immediately after acceptance.
   - IDLE and done at edge 4.
5. Assert reset while en_out=1 (between edges):
   - en_out=0 and addr_out=0 immediately.
   - No done pulse.
   - After release, req_ready=1 and a new request with req_addr=4 completes normally.
6. req_addr=3'bx1x with req_valid=1: err pulses, en_out stays 0 and the decoder model Y stays 8'hFF.
